// File: rtl/cookie_pkg.sv
// Shared defaults and reader state encoding for the cookie grid readout path.
package cookie_pkg;

   localparam int DEFAULT_GRID_W = 16;
   localparam int DEFAULT_GRID_H = 16;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      SHIFT,
      EMIT,
      DONE
   } reader_state_t;

endpackage

// File: rtl/cookie_row_deser.sv
// Row deserializer: collects GRID_W serial bits MSB-first into one row.
// full marks the shift that completes the row.
module cookie_row_deser
   import cookie_pkg::*;
#(
   parameter int GRID_W = DEFAULT_GRID_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift,
   input  logic              serial_in,
   output logic [GRID_W-1:0] row_data,
   output logic              full
);

   localparam int CNT_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;

   logic [CNT_W-1:0] bit_cnt;

   assign full = shift && (bit_cnt == CNT_W'(GRID_W - 1));

   // The first bit of a row is the highest column, so it ends up in the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_data <= '0;
         bit_cnt  <= '0;
      end else if (shift) begin
         row_data <= {row_data[GRID_W-2:0], serial_in};
         bit_cnt  <= full ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cookie_reader.sv
// Readout end of the grid display chain: snapshots the grid, shifts it out and
// hands reassembled rows (highest row first) downstream over valid/ready.
module cookie_reader
   import cookie_pkg::*;
#(
   parameter int GRID_W = DEFAULT_GRID_W,
   parameter int GRID_H = DEFAULT_GRID_H
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      serial_in,
   output logic                      display,
   output logic                      shift_en,
   output logic                      freeze,
   output logic                      busy,
   output logic [GRID_W-1:0]         row_data,
   output logic [$clog2(GRID_H)-1:0] row_idx,
   output logic                      row_valid,
   input  logic                      row_ready,
   output logic                      frame_done
);

   localparam int ROW_W = $clog2(GRID_H);

   reader_state_t    state, state_next;
   logic [ROW_W-1:0] row_cnt;
   logic [GRID_W-1:0] deser_data;
   logic             row_full;
   logic             row_accept;

   cookie_row_deser #(
      .GRID_W(GRID_W)
   ) u_deser (
      .clk      (clk),
      .rst      (rst),
      .shift    (shift_en),
      .serial_in(serial_in),
      .row_data (deser_data),
      .full     (row_full)
   );

   assign row_accept = row_valid && row_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Rows leave highest index first; reload after the last one so the next frame starts clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt <= ROW_W'(GRID_H - 1);
      end else if (row_accept) begin
         row_cnt <= (row_cnt == '0) ? ROW_W'(GRID_H - 1) : row_cnt - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      display    = 1'b0;
      shift_en   = 1'b0;
      row_valid  = 1'b0;
      frame_done = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = SNAP;
         end
         SNAP: begin
            display    = 1'b1;
            busy       = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            busy     = 1'b1;
            if (row_full) state_next = EMIT;
         end
         EMIT: begin
            row_valid = 1'b1;
            busy      = 1'b1;
            if (row_ready) state_next = (row_cnt == '0) ? DONE : SHIFT;
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The chain stalls during EMIT, so the deserializer already holds row_data stable.
   assign freeze   = busy;
   assign row_data = row_valid ? deser_data : '0;
   assign row_idx  = row_valid ? row_cnt : '0;

endmodule

// File: tb/tb_cookie_reader.sv
// Bench for cookie_reader: a shift-chain grid model feeds the DUT, and a per-cycle
// frame model checks strobes, busy, rows and frame timing.
module tb_cookie_reader;
   import cookie_pkg::*;

   localparam int W = 16;
   localparam int H = 16;
   localparam int N = W * H;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         serial_in;
   logic         display;
   logic         shift_en;
   logic         freeze;
   logic         busy;
   logic [W-1:0] row_data;
   logic [3:0]   row_idx;
   logic         row_valid;
   logic         row_ready;
   logic         frame_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cookie_reader #(
      .GRID_W(W),
      .GRID_H(H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .serial_in (serial_in),
      .display   (display),
      .shift_en  (shift_en),
      .freeze    (freeze),
      .busy      (busy),
      .row_data  (row_data),
      .row_idx   (row_idx),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .frame_done(frame_done)
   );

   // Grid side: display loads every cell into the chain, cell N-1 comes out first.
   logic [H-1:0][W-1:0] grid_cells = '0;
   logic [N-1:0]        chain = '0;
   assign serial_in = chain[N-1];

   always @(posedge clk) begin
      if (display) chain <= grid_cells;
      else if (shift_en) chain <= {chain[N-2:0], 1'b0};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Frame model state: what each output must be in the current cycle.
   logic [W-1:0] snap_rows [H];
   logic [W-1:0] got_rows  [H];
   int  exp_row    = H - 1;
   bit  m_busy     = 1'b0;
   bit  m_done     = 1'b0;
   bit  m_disp     = 1'b0;
   bit  m_rst_prev = 1'b1;
   bit  checking   = 1'b0;
   bit  n_accept, last_row, n_disp;
   int  shift_cnt  = 0;
   int  rows_seen  = 0;
   int  accept_cyc = 0;
   int  done_cyc   = 0;
   int  done_count = 0;

   always @(negedge clk) begin
      if (checking) begin
         check_output("busy", busy, m_busy);
         check_output("freeze", freeze, m_busy);
         check_output("frame_done", frame_done, m_done);
         check_output("display", display, m_disp);
         check_output("display_and_shift", display & shift_en, 1'b0);
         check_output("shift_during_emit", shift_en & row_valid, 1'b0);
         check_output("row_valid_outside_frame", row_valid & ~m_busy, 1'b0);
         if (m_rst_prev) begin
            check_output("reset_shift_en", shift_en, 1'b0);
            check_output("reset_row_valid", row_valid, 1'b0);
            check_output("reset_row_data", row_data, '0);
            check_output("reset_row_idx", row_idx, '0);
         end
         if (m_disp) begin
            for (int r = 0; r < H; r++) snap_rows[r] = grid_cells[r];
            shift_cnt = 0;
            rows_seen = 0;
         end
         if (row_valid) begin
            check_output("row_idx", row_idx, exp_row);
            check_output("row_data", row_data, snap_rows[exp_row]);
         end
         if (shift_en) shift_cnt++;
         if (m_done) begin
            check_output("shifts_per_frame", shift_cnt, N);
            check_output("rows_per_frame", rows_seen, H);
            done_count++;
            done_cyc = cyc;
         end

         if (rst) begin
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_disp     = 1'b0;
            exp_row    = H - 1;
            m_rst_prev = 1'b1;
         end else begin
            n_accept = row_valid && row_ready;
            last_row = n_accept && (exp_row == 0);
            if (n_accept) begin
               got_rows[exp_row] = row_data;
               rows_seen++;
               exp_row = (exp_row == 0) ? H - 1 : exp_row - 1;
            end
            n_disp = !m_busy && !m_done && start;
            if (n_disp) accept_cyc = cyc;
            m_busy     = n_disp ? 1'b1 : (last_row ? 1'b0 : m_busy);
            m_done     = last_row;
            m_disp     = n_disp;
            m_rst_prev = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (frame_done !== 1'b1 && k < limit) begin
         tick(1);
         k++;
      end
      check_output("frame_done_timeout", k < limit, 1'b1);
   endtask

   task automatic wait_row(input int idx, input int limit);
      int k = 0;
      while (!(row_valid === 1'b1 && row_idx == 4'(idx)) && k < limit) begin
         tick(1);
         k++;
      end
      check_output("row_wait_timeout", k < limit, 1'b1);
   endtask

   task automatic load_checkerboard();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            grid_cells[r][c] = 1'((r + c) & 1);
   endtask

   task automatic check_checker_rows(input string name);
      logic [W-1:0] want;
      for (int r = 0; r < H; r++) begin
         want = (r % 2 == 1) ? 16'h5555 : 16'hAAAA;
         check_output(name, got_rows[r], want);
      end
   endtask

   int d0, d_first;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      row_ready = 1'b1;
      tick(1);
      checking = 1'b1;
      check_output("reset_busy", busy, 1'b0);
      check_output("reset_display", display, 1'b0);
      check_output("reset_frame_done", frame_done, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Checkerboard frame with ready tied high: timing and row contents.
      load_checkerboard();
      apply_stimulus_start();
      wait_done(400);
      tick(1);
      check_output("t1_done_latency", done_cyc - accept_cyc, 274);
      check_checker_rows("t1_row");

      // One lit cell at row 3, col 7.
      grid_cells = '0;
      grid_cells[3][7] = 1'b1;
      tick(2);
      apply_stimulus_start();
      wait_done(400);
      tick(1);
      for (int r = 0; r < H; r++)
         check_output("t2_row", got_rows[r], (r == 3) ? 16'h0080 : 16'h0000);

      // Downstream stalls 5 cycles on row 10.
      load_checkerboard();
      tick(2);
      apply_stimulus_start();
      wait_row(11, 400);
      tick(1);
      row_ready = 1'b0;
      wait_row(10, 100);
      tick(5);
      check_output("t3_row_held", row_valid, 1'b1);
      check_output("t3_idx_held", row_idx, 4'd10);
      row_ready = 1'b1;
      wait_done(400);
      tick(1);
      check_checker_rows("t3_row");

      // start re-pulsed mid-frame is ignored.
      d0 = done_count;
      apply_stimulus_start();
      tick(10);
      apply_stimulus_start();
      wait_done(400);
      tick(20);
      check_output("t4_single_done", done_count - d0, 1);

      // start held high: back-to-back frames with one idle cycle between.
      d0 = done_count;
      start = 1'b1;
      wait_done(400);
      tick(1);
      d_first = done_cyc;
      wait_done(400);
      start = 1'b0;
      tick(1);
      check_output("t4_back_to_back", done_count - d0, 2);
      check_output("t4_frame_gap", done_cyc - d_first, 275);

      // Reset while row 8 is waiting for ready, then a clean frame.
      tick(3);
      apply_stimulus_start();
      wait_row(9, 400);
      tick(1);
      row_ready = 1'b0;
      wait_row(8, 100);
      tick(2);
      rst = 1'b1;
      tick(1);
      check_output("t5_rst_busy", busy, 1'b0);
      check_output("t5_rst_row_valid", row_valid, 1'b0);
      check_output("t5_rst_row_data", row_data, '0);
      rst       = 1'b0;
      row_ready = 1'b1;
      tick(2);
      apply_stimulus_start();
      wait_done(400);
      tick(1);
      check_checker_rows("t5_row");

      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
